// File: rtl/csr_if.sv
// CSR access and trap-control bundle between the execute stage and the CSR file.
interface csr_if;
    logic [11:0] csr_adr;
    logic [1:0]  csr_op_ctr;
    logic        csr_wr_en;
    logic        csr_read_en;
    logic        csr_imm_en;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic        inst_retire;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] trap_vector;
    logic [31:0] epc_out;
    logic        mie_out;

    modport master (
        output csr_adr, csr_op_ctr, csr_wr_en, csr_read_en, csr_imm_en, rs1_data, zimm,
               inst_retire, trap_req, trap_cause, trap_pc, mret,
        input  csr_rdata, csr_illegal, trap_vector, epc_out, mie_out
    );

    modport slave (
        input  csr_adr, csr_op_ctr, csr_wr_en, csr_read_en, csr_imm_en, rs1_data, zimm,
               inst_retire, trap_req, trap_cause, trap_pc, mret,
        output csr_rdata, csr_illegal, trap_vector, epc_out, mie_out
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSRRW/S/C (reg or imm form), trap/mret state and 64-bit
// mcycle/minstret counters. Read data is combinational and shows the pre-write value.
module csr_file #(
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input logic   clk,
    input logic   rst,
    csr_if.slave  csr_bus
);
    localparam logic [11:0] ADR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADR_MISA      = 12'h301;
    localparam logic [11:0] ADR_MTVEC     = 12'h305;
    localparam logic [11:0] ADR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADR_MEPC      = 12'h341;
    localparam logic [11:0] ADR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADR_MHARTID   = 12'hF14;

    logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause;
    logic        r_mie, r_mpie;
    logic [63:0] r_mcycle, r_minstret;

    logic        w_impl, w_ro, w_illegal, w_we;
    logic [31:0] w_old, w_opnd, w_wdata, w_mstatus;
    logic [63:0] w_cyc_nxt, w_ins_nxt;

    // MPP is hardwired to machine mode; only MIE and MPIE are stored.
    assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};

    always_comb begin
        w_impl = 1'b1;
        w_ro   = 1'b0;
        w_old  = 32'd0;
        case (csr_bus.csr_adr)
            ADR_MSTATUS:   w_old = w_mstatus;
            ADR_MTVEC:     w_old = r_mtvec;
            ADR_MSCRATCH:  w_old = r_mscratch;
            ADR_MEPC:      w_old = r_mepc;
            ADR_MCAUSE:    w_old = r_mcause;
            ADR_MCYCLE:    w_old = r_mcycle[31:0];
            ADR_MCYCLEH:   w_old = r_mcycle[63:32];
            ADR_MINSTRET:  w_old = r_minstret[31:0];
            ADR_MINSTRETH: w_old = r_minstret[63:32];
            ADR_MISA: begin
                w_old = MISA_VAL;
                w_ro  = 1'b1;
            end
            ADR_MHARTID: begin
                w_old = HART_ID;
                w_ro  = 1'b1;
            end
            default:       w_impl = 1'b0;
        endcase
    end

    assign w_illegal = ((csr_bus.csr_read_en | csr_bus.csr_wr_en) & ~w_impl)
                     | (csr_bus.csr_wr_en & w_ro);

    assign csr_bus.csr_rdata   = (csr_bus.csr_read_en && !w_illegal) ? w_old : 32'd0;
    assign csr_bus.csr_illegal = w_illegal;
    assign csr_bus.trap_vector = r_mtvec;
    assign csr_bus.epc_out     = r_mepc;
    assign csr_bus.mie_out     = r_mie;

    assign w_opnd = csr_bus.csr_imm_en ? {27'd0, csr_bus.zimm} : csr_bus.rs1_data;

    always_comb begin
        case (csr_bus.csr_op_ctr)
            2'd0:    w_wdata = w_opnd;
            2'd1:    w_wdata = w_old | w_opnd;
            2'd2:    w_wdata = w_old & ~w_opnd;
            default: w_wdata = w_old;
        endcase
    end

    // Trap and mret both pre-empt a CSR write issued in the same cycle.
    assign w_we = csr_bus.csr_wr_en && (csr_bus.csr_op_ctr != 2'd3) && !w_illegal
               && !csr_bus.trap_req && !csr_bus.mret;

    // The written half overrides; the other half keeps the incremented 64-bit result.
    always_comb begin
        w_cyc_nxt = r_mcycle + 64'd1;
        w_ins_nxt = r_minstret + {63'd0, csr_bus.inst_retire};
        if (w_we) begin
            case (csr_bus.csr_adr)
                ADR_MCYCLE:    w_cyc_nxt[31:0]  = w_wdata;
                ADR_MCYCLEH:   w_cyc_nxt[63:32] = w_wdata;
                ADR_MINSTRET:  w_ins_nxt[31:0]  = w_wdata;
                ADR_MINSTRETH: w_ins_nxt[63:32] = w_wdata;
                default:       ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= 32'd0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            r_mcycle   <= w_cyc_nxt;
            r_minstret <= w_ins_nxt;
            if (csr_bus.trap_req) begin
                r_mepc   <= {csr_bus.trap_pc[31:2], 2'b00};
                r_mcause <= csr_bus.trap_cause;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (csr_bus.mret) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_we) begin
                case (csr_bus.csr_adr)
                    ADR_MSTATUS: begin
                        r_mie  <= w_wdata[3];
                        r_mpie <= w_wdata[7];
                    end
                    ADR_MTVEC:    r_mtvec    <= {w_wdata[31:2], 2'b00};
                    ADR_MSCRATCH: r_mscratch <= w_wdata;
                    ADR_MEPC:     r_mepc     <= {w_wdata[31:2], 2'b00};
                    ADR_MCAUSE:   r_mcause   <= w_wdata;
                    default:      ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed vector table, hand-written counter/trap/reset sequences
// and randomized accesses checked against a behavioural CSR model.
module tb_csr_file;
    localparam logic [31:0] MTVEC_RST = 32'h8000_0000;
    localparam logic [31:0] MISA_V    = 32'h4000_0100;

    logic clk;
    logic rst;
    csr_if bus ();

    csr_file #(
        .MISA_VAL    (MISA_V),
        .HART_ID     (32'h0),
        .MTVEC_RESET (MTVEC_RST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .csr_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] adr;
        logic [1:0]  op;
        logic        wr;
        logic        rd;
        logic        imm;
        logic [31:0] rs1;
        logic [4:0]  zimm;
        logic        retire;
        logic        trap;
        logic [31:0] cause;
        logic [31:0] pc;
        logic        mret;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ins;

    task automatic model_reset();
        m_mie = 1'b0; m_mpie = 1'b0;
        m_mtvec = MTVEC_RST; m_mscratch = 32'd0; m_mepc = 32'd0; m_mcause = 32'd0;
        m_cyc = 64'd0; m_ins = 64'd0;
    endtask

    function automatic logic [31:0] m_val(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h301: return MISA_V;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_ill(input logic rd, input logic wr, input logic [11:0] a);
        logic impl;
        impl = a inside {12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14};
        return ((rd || wr) && !impl) || (wr && (a == 12'h301 || a == 12'hF14));
    endfunction

    function automatic logic [31:0] m_rdata(input logic rd, input logic wr, input logic [11:0] a);
        return (rd && !m_ill(rd, wr, a)) ? m_val(a) : 32'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [11:0] adr, input logic [1:0] op, input logic wr,
                                input logic rd, input logic imm, input logic [31:0] rs1,
                                input logic [4:0] zimm, input logic [31:0] exp_rdata,
                                input logic exp_ill);
        vec_t v;
        v.adr = adr; v.op = op; v.wr = wr; v.rd = rd; v.imm = imm; v.rs1 = rs1;
        v.zimm = zimm; v.retire = 1'b0; v.trap = 1'b0; v.cause = 32'd0; v.pc = 32'd0;
        v.mret = 1'b0; v.exp_rdata = exp_rdata; v.exp_ill = exp_ill;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.csr_adr = v.adr; bus.csr_op_ctr = v.op; bus.csr_wr_en = v.wr;
        bus.csr_read_en = v.rd; bus.csr_imm_en = v.imm; bus.rs1_data = v.rs1;
        bus.zimm = v.zimm; bus.inst_retire = v.retire; bus.trap_req = v.trap;
        bus.trap_cause = v.cause; bus.trap_pc = v.pc; bus.mret = v.mret;
    endtask

    task automatic chk_side();
        chk("trap_vector", bus.trap_vector, m_mtvec);
        chk("epc_out", bus.epc_out, m_mepc);
        chk("mie_out", {31'd0, bus.mie_out}, {31'd0, m_mie});
    endtask

    // Advance one clock, applying the architectural rules to the model.
    task automatic tick();
        logic [31:0] opv, old, wd;
        logic [63:0] nc, ni;
        logic        we;
        logic        n_mie, n_mpie;
        logic [31:0] n_mtvec, n_mscratch, n_mepc, n_mcause;
        opv = bus.csr_imm_en ? {27'd0, bus.zimm} : bus.rs1_data;
        old = m_val(bus.csr_adr);
        case (bus.csr_op_ctr)
            2'd0:    wd = opv;
            2'd1:    wd = old | opv;
            2'd2:    wd = old & ~opv;
            default: wd = old;
        endcase
        nc = m_cyc + 64'd1;
        ni = m_ins + (bus.inst_retire ? 64'd1 : 64'd0);
        n_mie = m_mie; n_mpie = m_mpie; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
        n_mepc = m_mepc; n_mcause = m_mcause;
        we = bus.csr_wr_en && bus.csr_op_ctr != 2'd3
             && !m_ill(bus.csr_read_en, bus.csr_wr_en, bus.csr_adr);
        if (bus.trap_req) begin
            n_mepc = bus.trap_pc & ~32'd3; n_mcause = bus.trap_cause;
            n_mpie = m_mie; n_mie = 1'b0;
        end else if (bus.mret) begin
            n_mie = m_mpie; n_mpie = 1'b1;
        end else if (we) begin
            case (bus.csr_adr)
                12'h300: begin n_mie = wd[3]; n_mpie = wd[7]; end
                12'h305: n_mtvec = wd & ~32'd3;
                12'h340: n_mscratch = wd;
                12'h341: n_mepc = wd & ~32'd3;
                12'h342: n_mcause = wd;
                12'hB00: nc = {nc[63:32], wd};
                12'hB80: nc = {wd, nc[31:0]};
                12'hB02: ni = {ni[63:32], wd};
                12'hB82: ni = {wd, ni[31:0]};
                default: ;
            endcase
        end
        @(posedge clk);
        m_mie = n_mie; m_mpie = n_mpie; m_mtvec = n_mtvec; m_mscratch = n_mscratch;
        m_mepc = n_mepc; m_mcause = n_mcause; m_cyc = nc; m_ins = ni;
        #1;
    endtask

    task automatic run(input string name, input vec_t v);
        drive(v);
        #2;
        chk({name, ".rdata"}, bus.csr_rdata, v.exp_rdata);
        chk({name, ".illegal"}, {31'd0, bus.csr_illegal}, {31'd0, v.exp_ill});
        chk_side();
        tick();
    endtask

    vec_t vecs[20];
    vec_t v;
    logic [11:0] adrs[13] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                              12'hB02, 12'hB80, 12'hB82, 12'hF14, 12'h7C0, 12'h000};

    initial begin
        model_reset();
        rst = 1'b1;
        drive(mk(12'h340, 2'd3, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0));
        #12;
        chk("rst.rdata_idle", bus.csr_rdata, 32'd0);
        chk("rst.illegal_idle", {31'd0, bus.csr_illegal}, 32'd0);
        chk_side();
        @(posedge clk); #1;
        rst = 1'b0;

        vecs[0]  = mk(12'hB00, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0);
        vecs[1]  = mk(12'h305, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, MTVEC_RST, 1'b0);
        vecs[2]  = mk(12'h300, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'h0000_1800, 1'b0);
        vecs[3]  = mk(12'h340, 2'd0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 5'd0, 32'd0, 1'b0);
        vecs[4]  = mk(12'h340, 2'd1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 5'h10, 32'hDEAD_BEEF, 1'b0);
        vecs[5]  = mk(12'h340, 2'd2, 1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 5'd0, 32'hDEAD_BEFF, 1'b0);
        vecs[6]  = mk(12'h340, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'h0000_BEFF, 1'b0);
        vecs[7]  = mk(12'h300, 2'd0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 5'd0, 32'h0000_1800, 1'b0);
        vecs[8]  = mk(12'h300, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'h0000_1888, 1'b0);
        vecs[9]  = mk(12'h300, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'h0000_1888, 1'b0);
        vecs[9].trap = 1'b1; vecs[9].pc = 32'h0000_0106; vecs[9].cause = 32'hB;
        vecs[10] = mk(12'h341, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'h0000_0104, 1'b0);
        vecs[11] = mk(12'h342, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'h0000_000B, 1'b0);
        vecs[12] = mk(12'h300, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'h0000_1880, 1'b0);
        vecs[12].mret = 1'b1;
        vecs[13] = mk(12'h300, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'h0000_1888, 1'b0);
        vecs[14] = mk(12'h301, 2'd0, 1'b1, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, 1'b1);
        vecs[15] = mk(12'h301, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, MISA_V, 1'b0);
        vecs[16] = mk(12'h7C0, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, 1'b1);
        vecs[17] = mk(12'hF14, 2'd1, 1'b1, 1'b1, 1'b0, 32'h1, 5'd0, 32'd0, 1'b1);
        vecs[18] = mk(12'h305, 2'd0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 5'd0, MTVEC_RST, 1'b0);
        vecs[19] = mk(12'h305, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'hFFFF_FFFC, 1'b0);
        for (int i = 0; i < 20; i++) run($sformatf("vec%0d", i), vecs[i]);

        // Counter carry: write high half first, then low half to all-ones.
        v = mk(12'hB80, 2'd0, 1'b1, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0);
        v.exp_rdata = m_rdata(1'b1, 1'b1, 12'hB80);
        run("cyc.wr_hi", v);
        v = mk(12'hB00, 2'd0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b0);
        v.exp_rdata = m_rdata(1'b1, 1'b1, 12'hB00);
        run("cyc.wr_lo", v);
        v = mk(12'hB02, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0);
        v.exp_rdata = m_rdata(1'b1, 1'b0, 12'hB02);
        run("ins.hold0", v);
        run("cyc.hi_carry", mk(12'hB80, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'd1, 1'b0));
        run("cyc.lo_after", mk(12'hB00, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'd1, 1'b0));
        v = mk(12'hB02, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0);
        v.exp_rdata = m_rdata(1'b1, 1'b0, 12'hB02);
        run("ins.hold1", v);

        // Trap wins over a same-cycle mepc write.
        v = mk(12'h341, 2'd0, 1'b1, 1'b1, 1'b0, 32'h200, 5'd0, 32'd0, 1'b0);
        v.trap = 1'b1; v.pc = 32'h0000_0123; v.cause = 32'h7;
        v.exp_rdata = m_rdata(1'b1, 1'b1, 12'h341);
        run("trap_vs_wr", v);
        run("trap.mepc", mk(12'h341, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'h120, 1'b0));
        run("trap.mcause", mk(12'h342, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'h7, 1'b0));

        // Randomized accesses against the model.
        for (int n = 0; n < 400; n++) begin
            v = mk(adrs[$urandom_range(0, 12)], 2'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom), 1'($urandom), $urandom, 5'($urandom), 32'd0, 1'b0);
            v.retire = 1'($urandom);
            v.trap = ($urandom_range(0, 15) == 0);
            v.mret = ($urandom_range(0, 15) == 0);
            v.cause = $urandom; v.pc = $urandom;
            v.exp_rdata = m_rdata(v.rd, v.wr, v.adr);
            v.exp_ill = m_ill(v.rd, v.wr, v.adr);
            run("rand", v);
        end

        // Reset asserted mid-cycle over a pending write and retire.
        v = mk(12'h340, 2'd0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 5'd0, 32'd0, 1'b0);
        v.retire = 1'b1;
        drive(v);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_mid.rdata", bus.csr_rdata, 32'd0);
        chk_side();
        @(posedge clk); #1;
        rst = 1'b0;
        run("post_rst.mcycle", mk(12'hB00, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0));
        run("post_rst.mscratch", mk(12'h340, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0));
        run("post_rst.minstret", mk(12'hB02, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 32'd0, 1'b0));
        run("post_rst.mstatus", mk(12'h300, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0,
                                   32'h0000_1800, 1'b0));
        run("post_rst.mtvec", mk(12'h305, 2'd3, 1'b0, 1'b1, 1'b0, 32'd0, 5'd0, MTVEC_RST, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
